// File: rtl/uart_drv_pkg.sv
// Shared encodings for the UART slot driver: FSM states, slot register map
// and status bit positions.
package uart_drv_pkg;

  typedef enum logic [2:0] {
    ST_CFG  = 3'd0,
    ST_STAT = 3'd1,
    ST_RXRD = 3'd2,
    ST_TXWR = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  typedef enum logic {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } dir_t;

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_DVSR   = 5'd1;
  localparam logic [4:0] ADDR_DATA   = 5'd2;

  localparam int unsigned STAT_TX_FULL_BIT  = 32'd9;
  localparam int unsigned STAT_RX_EMPTY_BIT = 32'd8;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'd0, b};
  endfunction

  function automatic logic [31:0] dvsr_word(input logic [10:0] d);
    return {21'd0, d};
  endfunction

endpackage

// File: rtl/uart_slot_driver_if.sv
// Slot bus between the driver (master) and the UART slot register file (slave).
interface uart_slot_driver_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, output read, output write, output addr, output wr_data,
                  input rd_data);
  modport slave  (input cs, input read, input write, input addr, input wr_data,
                  output rd_data);
endinterface

// File: rtl/uart_drv_hold.sv
// One-entry valid/ready byte register; a push and a pop may share one cycle.
module uart_drv_hold (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  logic       full_r;
  logic [7:0] data_r;
  logic       pop_s;
  logic       push_s;

  assign pop_s     = full_r & out_ready;
  assign in_ready  = enable & (~full_r | out_ready);
  assign push_s    = in_valid & in_ready;
  assign out_valid = full_r;
  assign out_data  = data_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r <= 1'b0;
      data_r <= 8'd0;
    end else begin
      full_r <= push_s | (full_r & ~pop_s);
      if (push_s) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule

// File: rtl/uart_slot_driver.sv
// Bus initiator for the UART slot: status-polled TX writes, RX reads, divisor setup.
// Optional UART_DRV_STATS_EN adds tx_count/rx_count access counters.
module uart_slot_driver
  import uart_drv_pkg::*;
#(
  parameter logic [10:0] DVSR_INIT       = 11'd650,
  parameter int unsigned STATUS_POLL_GAP = 32'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  uart_slot_driver_if.master        bus,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [7:0]                tx_byte,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [7:0]                rx_byte,
  input  logic                      cfg_wr,
  input  logic [10:0]               cfg_dvsr,
  output logic                      busy_cfg
`ifdef UART_DRV_STATS_EN
  ,
  output logic [15:0]               tx_count,
  output logic [15:0]               rx_count
`endif
);

  localparam int unsigned GAP_W = (STATUS_POLL_GAP > 32'd1) ? $clog2(STATUS_POLL_GAP) : 32'd1;
  localparam int unsigned GAP_LAST_INT = (STATUS_POLL_GAP > 32'd0) ? STATUS_POLL_GAP - 32'd1 : 32'd0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_INT);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             started_r;
  logic             pend_r;
  logic [10:0]      dvsr_r;
  dir_t             last_dir_r;
  logic [GAP_W-1:0] gap_cnt_r;

  logic       tx_hold_full_s;
  logic [7:0] tx_hold_data_s;
  logic       rx_space_s;
  logic       tx_full_s;
  logic       rx_empty_s;
  logic       rx_elig_s;
  logic       tx_elig_s;
  logic       rd_unused_s;

  assign tx_full_s   = bus.rd_data[STAT_TX_FULL_BIT];
  assign rx_empty_s  = bus.rd_data[STAT_RX_EMPTY_BIT];
  assign rd_unused_s = ^{bus.rd_data[31:10]};

  // The TX hold is drained by the TXWR access, so a new byte may land in the same cycle.
  uart_drv_hold u_tx_hold (
    .clk       (clk),
    .reset     (reset),
    .enable    (started_r),
    .in_valid  (tx_valid),
    .in_ready  (tx_ready),
    .in_data   (tx_byte),
    .out_valid (tx_hold_full_s),
    .out_ready (state_r == ST_TXWR),
    .out_data  (tx_hold_data_s)
  );

  uart_drv_hold u_rx_hold (
    .clk       (clk),
    .reset     (reset),
    .enable    (started_r),
    .in_valid  (state_r == ST_RXRD),
    .in_ready  (rx_space_s),
    .in_data   (bus.rd_data[7:0]),
    .out_valid (rx_valid),
    .out_ready (rx_ready),
    .out_data  (rx_byte)
  );

  assign rx_elig_s = ~rx_empty_s & rx_space_s;
  assign tx_elig_s = ~tx_full_s & tx_hold_full_s;
  assign busy_cfg  = pend_r | (state_r == ST_CFG);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CFG;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CFG: begin
        if (started_r) begin
          state_nxt_s = ST_STAT;
        end else begin
          state_nxt_s = ST_CFG;
        end
      end
      ST_STAT: begin
        if (pend_r) begin
          state_nxt_s = ST_CFG;
        end else if (rx_elig_s && tx_elig_s) begin
          state_nxt_s = (last_dir_r == DIR_TX) ? ST_RXRD : ST_TXWR;
        end else if (rx_elig_s) begin
          state_nxt_s = ST_RXRD;
        end else if (tx_elig_s) begin
          state_nxt_s = ST_TXWR;
        end else if (STATUS_POLL_GAP > 32'd0) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_STAT;
        end
      end
      ST_RXRD: state_nxt_s = ST_STAT;
      ST_TXWR: state_nxt_s = ST_STAT;
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = ST_STAT;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_CFG;
    endcase
  end

  // Bus outputs decoded from registers only; started_r keeps cs low until the first clock.
  always_comb begin
    bus.cs      = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = ADDR_STATUS;
    bus.wr_data = 32'd0;
    if (started_r) begin
      case (state_r)
        ST_CFG: begin
          bus.cs      = 1'b1;
          bus.write   = 1'b1;
          bus.addr    = ADDR_DVSR;
          bus.wr_data = dvsr_word(dvsr_r);
        end
        ST_STAT: begin
          bus.cs   = 1'b1;
          bus.read = 1'b1;
          bus.addr = ADDR_STATUS;
        end
        ST_RXRD: begin
          bus.cs   = 1'b1;
          bus.read = 1'b1;
          bus.addr = ADDR_DATA;
        end
        ST_TXWR: begin
          bus.cs      = 1'b1;
          bus.write   = 1'b1;
          bus.addr    = ADDR_DATA;
          bus.wr_data = byte_word(tx_hold_data_s);
        end
        ST_GAP:  bus.cs = 1'b0;
        default: bus.cs = 1'b0;
      endcase
    end else begin
      bus.cs = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_r <= 1'b0;
    end else begin
      started_r <= 1'b1;
    end
  end

  // A cfg_wr during CFG re-arms pending, so the newest divisor is always written last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= 1'b1;
      dvsr_r <= DVSR_INIT;
    end else if (cfg_wr) begin
      pend_r <= 1'b1;
      dvsr_r <= cfg_dvsr;
    end else if (started_r && (state_r == ST_CFG)) begin
      pend_r <= 1'b0;
      dvsr_r <= dvsr_r;
    end else begin
      pend_r <= pend_r;
      dvsr_r <= dvsr_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dir_r <= DIR_TX;
    end else if (state_r == ST_RXRD) begin
      last_dir_r <= DIR_RX;
    end else if (state_r == ST_TXWR) begin
      last_dir_r <= DIR_TX;
    end else begin
      last_dir_r <= last_dir_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_r <= '0;
    end else if (state_r == ST_GAP) begin
      gap_cnt_r <= gap_cnt_r + GAP_W'(1);
    end else begin
      gap_cnt_r <= '0;
    end
  end

`ifdef UART_DRV_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count <= 16'd0;
      rx_count <= 16'd0;
    end else begin
      tx_count <= (state_r == ST_TXWR) ? tx_count + 16'd1 : tx_count;
      rx_count <= (state_r == ST_RXRD) ? rx_count + 16'd1 : rx_count;
    end
  end
`endif

endmodule

// File: tb/tb_uart_slot_driver.sv
// Scoreboard bench for uart_slot_driver with a behavioural UART slot model.
module tb_uart_slot_driver;
  import uart_drv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_slot_driver_if bus ();

  logic        tx_valid, tx_ready, rx_valid, rx_ready, cfg_wr, busy_cfg;
  logic [7:0]  tx_byte, rx_byte;
  logic [10:0] cfg_dvsr;
`ifdef UART_DRV_STATS_EN
  logic [15:0] tx_count, rx_count;
`endif

  uart_slot_driver #(.DVSR_INIT(11'd650), .STATUS_POLL_GAP(32'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_byte  (rx_byte),
    .cfg_wr   (cfg_wr),
    .cfg_dvsr (cfg_dvsr),
    .busy_cfg (busy_cfg)
`ifdef UART_DRV_STATS_EN
    ,
    .tx_count (tx_count),
    .rx_count (rx_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Slot model state
  logic       tx_full_m;
  logic       rx_empty_m;
  logic [7:0] rx_head_m;
  logic [7:0] rx_q[$];
  bit         pop_pend = 1'b0;

  // Scoreboard
  logic [31:0] exp_cfg[$];
  logic [31:0] exp_tx[$];
  logic [7:0]  exp_rx[$];
  bit          acc_log[$];
  int tx_wr_cnt = 0, rx_rd_cnt = 0, stat_rd_cnt = 0, cfg_wr_cnt = 0;

  always_comb begin
    case (bus.addr)
      5'd0:    bus.rd_data = {22'd0, tx_full_m, rx_empty_m, 8'd0};
      5'd2:    bus.rd_data = {24'd0, rx_head_m};
      default: bus.rd_data = 32'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic rx_refresh();
    rx_empty_m = (rx_q.size() == 0);
    rx_head_m  = rx_empty_m ? 8'd0 : rx_q[0];
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    exp_tx.push_back({24'd0, b});
    tx_byte  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (tx_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    tx_valid = 1'b0;
    check("tx_accepted", {31'd0, ok}, 32'd1);
  endtask

  // Monitor: runs mid-low-phase, after the driver and before the next rising edge.
  always @(negedge clk) begin
    #3;
    if (pop_pend) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_pend = 1'b0;
      rx_refresh();
    end
    if (!reset && bus.cs) begin
      if (bus.write && bus.addr == ADDR_DVSR) begin
        cfg_wr_cnt++;
        if (exp_cfg.size() == 0) check("cfg_unexpected", bus.wr_data, 32'hFFFF_FFFF);
        else check("cfg_wdata", bus.wr_data, exp_cfg.pop_front());
      end else if (bus.write && bus.addr == ADDR_DATA) begin
        tx_wr_cnt++;
        acc_log.push_back(1'b0);
        check("tx_wr_not_full", {31'd0, tx_full_m}, 32'd0);
        if (exp_tx.size() == 0) check("tx_unexpected", bus.wr_data, 32'hFFFF_FFFF);
        else check("tx_wdata", bus.wr_data, exp_tx.pop_front());
      end else if (bus.read && bus.addr == ADDR_DATA) begin
        rx_rd_cnt++;
        acc_log.push_back(1'b1);
        check("rx_rd_not_empty", {31'd0, rx_empty_m}, 32'd0);
        check("rx_rd_wdata_zero", bus.wr_data, 32'd0);
        pop_pend = 1'b1;
      end else if (bus.read && bus.addr == ADDR_STATUS) begin
        stat_rd_cnt++;
        if (bus.wr_data != 32'd0) check("stat_wdata_zero", bus.wr_data, 32'd0);
      end else begin
        check("bad_access_addr", {27'd0, bus.addr}, 32'hFFFF_FFFF);
      end
    end
    if (!reset && rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) check("rx_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sbase, rbase, dbase, cbase, log_start;
    reset = 1'b1; tx_valid = 1'b0; tx_byte = 8'd0; rx_ready = 1'b0;
    cfg_wr = 1'b0; cfg_dvsr = 11'd0; tx_full_m = 1'b0;
    rx_refresh();
    repeat (3) step();

    // Reset state
    check("rst_cs", {31'd0, bus.cs}, 32'd0);
    check("rst_write", {31'd0, bus.write}, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_busy_cfg", {31'd0, busy_cfg}, 32'd1);

    // 1: first access is the divisor write, then a status read
    exp_cfg.push_back(32'd650);
    reset = 1'b0;
    step();
    check("t1_cs", {31'd0, bus.cs}, 32'd1);
    check("t1_write", {31'd0, bus.write}, 32'd1);
    check("t1_addr", {27'd0, bus.addr}, 32'd1);
    check("t1_wr_data", bus.wr_data, 32'd650);
    check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t1_busy_during", {31'd0, busy_cfg}, 32'd1);
    step();
    check("t1_stat_read", {31'd0, bus.read}, 32'd1);
    check("t1_stat_addr", {27'd0, bus.addr}, 32'd0);
    check("t1_busy_after", {31'd0, busy_cfg}, 32'd0);

    // 2: single byte, short latency, exactly one write
    base = tx_wr_cnt;
    send_tx(8'hA5);
    for (int i = 0; i < 3 && tx_wr_cnt == base; i++) step();
    check("t2_latency", tx_wr_cnt - base, 32'd1);
    repeat (8) step();
    check("t2_one_write", tx_wr_cnt - base, 32'd1);

    // 3: TX FIFO full holds the byte back while status keeps being polled
    tx_full_m = 1'b1;
    send_tx(8'h5A);
    base = tx_wr_cnt;
    sbase = stat_rd_cnt;
    repeat (10) step();
    check("t3_no_write", tx_wr_cnt - base, 32'd0);
    check("t3_polls", stat_rd_cnt - sbase, 32'd10);
    check("t3_tx_ready_low", {31'd0, tx_ready}, 32'd0);
    tx_full_m = 1'b0;
    repeat (4) step();
    check("t3_one_write", tx_wr_cnt - base, 32'd1);
    check("t3_tx_ready_high", {31'd0, tx_ready}, 32'd1);

    // 4: stalled consumer blocks further data reads
    rbase = rx_rd_cnt;
    rx_q.push_back(8'h3C); rx_q.push_back(8'h77);
    exp_rx.push_back(8'h3C); exp_rx.push_back(8'h77);
    rx_refresh();
    for (int i = 0; i < 5 && !rx_valid; i++) step();
    check("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("t4_rx_byte", {24'd0, rx_byte}, 32'h3C);
    repeat (10) step();
    check("t4_one_read", rx_rd_cnt - rbase, 32'd1);
    check("t4_byte_held", {24'd0, rx_byte}, 32'h3C);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    for (int i = 0; i < 6 && !rx_valid; i++) step();
    check("t4_second_read", rx_rd_cnt - rbase, 32'd2);
    check("t4_rx_byte2", {24'd0, rx_byte}, 32'h77);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    repeat (3) step();
    check("t4_rx_drained", {31'd0, rx_valid}, 32'd0);

    // 5: both directions busy, with a divisor update in the middle
    rx_ready = 1'b1;
    log_start = acc_log.size();
    for (int i = 0; i < 8; i++) begin
      rx_q.push_back(8'h10 + 8'(i));
      exp_rx.push_back(8'h10 + 8'(i));
    end
    rx_refresh();
    fork
      begin
        for (int i = 0; i < 8; i++) send_tx(8'h20 + 8'(i));
      end
      begin
        bit found;
        for (int i = 0; i < 40 && acc_log.size() < log_start + 4; i++) step();
        cfg_dvsr = 11'd26;
        cfg_wr = 1'b1;
        exp_cfg.push_back(32'd26);
        dbase = tx_wr_cnt + rx_rd_cnt;
        cbase = cfg_wr_cnt;
        step();
        cfg_wr = 1'b0;
        check("t5_busy_cfg", {31'd0, busy_cfg}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
          step();
          found = (cfg_wr_cnt != cbase);
        end
        check("t5_cfg_written", {31'd0, found}, 32'd1);
        check("t5_cfg_next_decision", {31'd0, (tx_wr_cnt + rx_rd_cnt - dbase) <= 1}, 32'd1);
        check("t5_busy_clear", {31'd0, busy_cfg}, 32'd0);
      end
    join
    for (int i = 0; i < 40 && (exp_rx.size() != 0 || exp_tx.size() != 0); i++) step();
    rx_ready = 1'b0;
    if (acc_log.size() >= log_start + 12) begin
      check("t5_first_rx", {31'd0, acc_log[log_start]}, 32'd1);
      for (int i = 1; i < 12; i++)
        check("t5_alternate", {31'd0, acc_log[log_start + i]}, {31'd0, !acc_log[log_start + i - 1]});
    end else begin
      check("t5_access_count", acc_log.size() - log_start, 32'd16);
    end

    // 6: reset during a TX write aborts it at once
    send_tx(8'hC3);
    for (int i = 0; i < 5; i++) begin
      if (bus.cs && bus.write && bus.addr == ADDR_DATA) break;
      step();
    end
    check("t6_in_txwr", {31'd0, bus.cs && bus.write && bus.addr == ADDR_DATA}, 32'd1);
    reset = 1'b1;
    if (exp_tx.size() > 0) void'(exp_tx.pop_back());
    #1;
    check("t6_cs_drop", {31'd0, bus.cs}, 32'd0);
    check("t6_write_drop", {31'd0, bus.write}, 32'd0);
    check("t6_tx_ready_drop", {31'd0, tx_ready}, 32'd0);
    repeat (2) step();
    exp_cfg.push_back(32'd650);
    reset = 1'b0;
    step();
    check("t6_restart_cfg", {31'd0, bus.cs && bus.write && bus.addr == ADDR_DVSR}, 32'd1);
    check("t6_restart_dvsr", bus.wr_data, 32'd650);
    step();
    check("t6_then_status", {31'd0, bus.cs && bus.read && bus.addr == ADDR_STATUS}, 32'd1);

    repeat (5) step();
    check("end_exp_tx_empty", exp_tx.size(), 32'd0);
    check("end_exp_rx_empty", exp_rx.size(), 32'd0);
    check("end_exp_cfg_empty", exp_cfg.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_slot_driver.md
Name: uart_slot_driver

Overview:
- Bus initiator for the UART slot register map: drives cs/read/write/addr/wr_data and samples rd_data.
- Converts a valid/ready byte stream into TX data writes and returns RX data reads as a valid/ready byte stream.
- Programs the baud divisor after reset and on request.
- Sits between an on-chip byte producer/consumer and the UART slot, in place of a CPU.

Parameters:
- DVSR_INIT, 11'd650, divisor written after reset (100 MHz, 9600 baud, 16x oversampling).
- STATUS_POLL_GAP, 0, idle cycles inserted after a status read that finds nothing to do (0 = back-to-back polling).

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- cs  out  1  slot select
- read  out  1  slot read strobe
- write  out  1  slot write strobe
- addr  out  5  slot register address
- wr_data  out  32  slot write data
- rd_data  in  32  slot read data; combinational from addr, valid in the same cycle
- tx_valid  in  1  producer has a byte
- tx_ready  out  1  driver accepts the byte this cycle
- tx_byte  in  8  byte to transmit
- rx_valid  out  1  received byte available
- rx_ready  in  1  consumer takes the byte this cycle
- rx_byte  out  8  received byte
- cfg_wr  in  1  one-cycle pulse requesting a divisor update
- cfg_dvsr  in  11  new divisor, sampled when cfg_wr = 1
- busy_cfg  out  1  divisor write pending or in progress

Behaviour:
- Register map: addr 0 = status, read only; rd_data[9] = tx_full, rd_data[8] = rx_empty. addr 1 = divisor, write only, wr_data[10:0]. addr 2 = data; write pushes TX, read pops RX.
- Bus cycle:
  - Every slot access lasts exactly one clk with cs = 1.
  - cs, read, write, addr and wr_data are registered, or decoded from the state register only. There is no combinational path from any input to them.
  - rd_data is sampled at the rising edge that ends the read cycle.
  - Unused wr_data bits are 0. wr_data is 0 on reads and when idle.
- FSM states:
  - CFG: write addr 1. Next state STAT.
  - STAT: read addr 0; capture tx_full and rx_empty. Next state per the decision rules below.
  - RXRD: read addr 2; load rx_byte and set rx_valid. Next state STAT.
  - TXWR: write addr 2 with the TX hold register in wr_data[7:0]; clear the hold register. Next state STAT.
  - GAP: wait STATUS_POLL_GAP cycles, then go to STAT.
- Decision at the end of STAT, in priority order:
  1. cfg pending -> CFG.
  2. Otherwise, candidates are:
     - RX eligible: rx_empty = 0 and (rx_valid = 0 or rx_ready = 1 this cycle).
     - TX eligible: tx_full = 0 and TX hold register full.
  3. Both eligible: round-robin, serving the opposite of the last served direction. last_served resets to TX, so RX wins the first tie.
  4. Exactly one eligible -> that state.
  5. None eligible -> GAP, or straight to STAT when STATUS_POLL_GAP = 0.
- TX hold register: tx_ready = !hold_full. A byte is accepted when tx_valid and tx_ready are both 1. Acceptance in the same cycle as TXWR is allowed, since the hold register is freed that edge.
- RX hold register: rx_valid drops on rx_valid and rx_ready. If RXRD completes in that same cycle, rx_valid stays 1 with the new byte.
- Divisor writes:
  - After reset: the first bus access is CFG with DVSR_INIT, and busy_cfg = 1 until CFG completes.
  - cfg_wr latches cfg_dvsr into a pending register and sets pending.
  - A cfg_wr that arrives during CFG re-arms pending with the new value, so the last value always wins.
- Status is re-read before every data access, so the driver never writes to a full TX FIFO or reads an empty RX FIFO.
- Latency:
  - TX byte accepted while idle polling with STATUS_POLL_GAP = 0: bus write occurs within 2–3 cycles.
  - RX data read happens at most 2 accesses after a status read shows rx_empty = 0.
- Reset: asynchronous. State -> CFG; all bus outputs, tx_ready, rx_valid, rx_byte and hold registers -> 0; busy_cfg -> 1. A reset mid-access aborts it immediately and cs drops asynchronously.
- tx_ready is 1 from the first clk after reset deasserts.

Optional Feature:
- UART_DRV_STATS_EN defined:
  - Adds outputs tx_count[15:0] and rx_count[15:0].
  - tx_count increments on each TXWR; rx_count increments on each RXRD.
  - Both wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package uart_drv_pkg holds:
  - state encoding (CFG, STAT, RXRD, TXWR, GAP);
  - ADDR_STATUS = 0, ADDR_DVSR = 1, ADDR_DATA = 2;
  - STAT_TX_FULL_BIT = 9, STAT_RX_EMPTY_BIT = 8.
- Sub-module uart_drv_hold: one-entry valid/ready byte register, instantiated twice (TX hold and RX hold).

Test Plan:
1. Reset release -> first access: cs = 1, write = 1, addr = 1, wr_data = 32'd650; busy_cfg falls; next access is a status read at addr 0.
2. Send tx_byte 8'hA5 with status returning tx_full = 0 -> a write to addr 2 with wr_data = 32'h000000A5 follows within 3 cycles; exactly one write.
3. Status returns tx_full = 1 while a byte is held -> no write to addr 2 and repeated status polls; when tx_full = 0, exactly one write occurs.
4. rx_empty = 0 with data 8'h3C, rx_ready = 0 -> rx_valid = 1, rx_byte = 8'h3C; no further addr-2 reads until rx_ready pulses.
5. RX and TX both eligible continuously -> data accesses alternate RX, TX, RX, TX; cfg_wr with 11'd26 mid-stream -> next decision issues a write to addr 1 with 26.
6. Assert reset during a TXWR cycle -> cs, write and tx_ready drop immediately; after release the sequence restarts with CFG.
